// File: rtl/csk_sub_pkg.sv
// Shared constants and types for the block-serial carry-skip subtractor.
//   WIDTH : operand/result width in bits
//   BLK   : carry-skip block width processed per clock
//   NB    : number of blocks, ceil(WIDTH/BLK)
//   IDX_W : width of the block-index counter
//   LAST_W: number of valid bits in the final (possibly partial) block
package csk_sub_pkg;

    localparam int unsigned WIDTH  = 11;
    localparam int unsigned BLK    = 2;
    localparam int unsigned NB     = (WIDTH + BLK - 1) / BLK;
    localparam int unsigned IDX_W  = (NB > 1) ? $clog2(NB) : 1;
    localparam int unsigned LAST_W = WIDTH - BLK * (NB - 1);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

endpackage

// File: rtl/csk_sub_block.sv
// One carry-skip block of the serial subtractor (purely combinational).
// The caller supplies the minuend bits and the already-inverted subtrahend bits.
// Ports:
//   a        : minuend slice
//   b_inv    : inverted subtrahend slice
//   cin      : carry into the block
//   mask     : 1 for bits that exist in the operand (contiguous from bit 0)
//   s        : sum bits (only masked-in bits are meaningful)
//   cout     : carry out of the highest valid bit, ripple OR skip
//   c_msb_in : carry into the highest valid bit
module csk_sub_block #(
    parameter int unsigned BlkW = 2
) (
    input  logic [BlkW-1:0] a,
    input  logic [BlkW-1:0] b_inv,
    input  logic            cin,
    input  logic [BlkW-1:0] mask,
    output logic [BlkW-1:0] s,
    output logic            cout,
    output logic            c_msb_in
);

    logic [BlkW-1:0] p;
    logic [BlkW-1:0] g;
    logic [BlkW:0]   c;
    logic            skip;

    always_comb begin
        // Missing bits are made transparent (propagate, never generate) so the
        // carry out of the top valid bit travels unchanged to the block output.
        p    = (a ^ b_inv) | ~mask;
        g    = a & b_inv & mask;
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < BlkW; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
        s    = (a ^ b_inv) ^ c[BlkW-1:0];
        skip = (&p) & cin;
        cout = c[BlkW] | skip;
        c_msb_in = cin;
        for (int i = 0; i < BlkW; i++) begin
            if (mask[i]) begin
                c_msb_in = c[i];
            end
        end
    end

endmodule

// File: rtl/csk_serial_subtractor.sv
// Block-serial two's-complement subtractor: d = x - y, one BLK-bit carry-skip
// block per clock, computed as x + ~y + 1.
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   in_valid, in_ready  : operand handshake (accepted only in idle)
//   x, y                : minuend, subtrahend
//   out_valid, out_ready: result handshake (result held until taken)
//   d                   : difference modulo 2^WIDTH
//   borrow              : x < y unsigned (inverse of final carry)
//   ovf                 : signed overflow
module csk_serial_subtractor
    import csk_sub_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
    output logic             borrow,
    output logic             ovf
);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   x_q, x_d;
    logic [WIDTH-1:0]   yn_q, yn_d;
    logic [IDX_W-1:0]   blk_q, blk_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   d_q, d_d;
    logic               borrow_q, borrow_d;
    logic               ovf_q, ovf_d;

    logic [BLK-1:0]     blk_a;
    logic [BLK-1:0]     blk_b;
    logic [BLK-1:0]     blk_mask;
    logic [BLK-1:0]     blk_s;
    logic               blk_cout;
    logic               blk_c_msb_in;
    logic               last_blk;

    // Route the operand bits of the current block to the block adder; bits
    // beyond WIDTH stay masked out in the partial last block.
    always_comb begin
        blk_a    = '0;
        blk_b    = '0;
        blk_mask = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (IDX_W'(i / BLK) == blk_q) begin
                blk_a[i % BLK]    = x_q[i];
                blk_b[i % BLK]    = yn_q[i];
                blk_mask[i % BLK] = 1'b1;
            end
        end
    end

    csk_sub_block #(
        .BlkW (BLK)
    ) u_block (
        .a        (blk_a),
        .b_inv    (blk_b),
        .cin      (carry_q),
        .mask     (blk_mask),
        .s        (blk_s),
        .cout     (blk_cout),
        .c_msb_in (blk_c_msb_in)
    );

    assign last_blk = (blk_q == IDX_W'(NB - 1));

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        yn_d     = yn_q;
        blk_d    = blk_q;
        carry_d  = carry_q;
        d_d      = d_q;
        borrow_d = borrow_q;
        ovf_d    = ovf_q;
        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    x_d     = x;
                    yn_d    = ~y;
                    carry_d = 1'b1;
                    blk_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                carry_d = blk_cout;
                for (int i = 0; i < int'(WIDTH); i++) begin
                    if (IDX_W'(i / BLK) == blk_q) begin
                        d_d[i] = blk_s[i % BLK];
                    end
                end
                if (last_blk) begin
                    borrow_d = ~blk_cout;
                    ovf_d    = blk_c_msb_in ^ blk_cout;
                    state_d  = StDone;
                end else begin
                    blk_d = blk_q + IDX_W'(1);
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            x_q      <= '0;
            yn_q     <= '0;
            blk_q    <= '0;
            carry_q  <= 1'b0;
            d_q      <= '0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            yn_q     <= yn_d;
            blk_q    <= blk_d;
            carry_q  <= carry_d;
            d_q      <= d_d;
            borrow_q <= borrow_d;
            ovf_q    <= ovf_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign d         = d_q;
    assign borrow    = borrow_q;
    assign ovf       = ovf_q;

endmodule
